fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have ports: rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports: imem_req  out  1  fetch request; imem_addr  out  32  word-aligned fetch address.
REQ-005 SHALL have ports: imem_ack  in  1  fetch data valid; imem_rdata  in  32  instruction word.
REQ-006 SHALL have ports: redirect_valid  in  1  branch/jump taken; redirect_pc  in  32  new fetch address.
REQ-007 SHALL have ports: dec_valid  out  1  control word valid; dec_ready  in  1  datapath accepts control word.
REQ-008 SHALL have ports: instType  out  4; fun3  out  3; fun7  out  1; rd, rs1, rs2  out  5 each; pc  out  32; imm  out  32; illegal  out  1.

Function
REQ-009 SHALL implement FSM states IDLE, FETCH, DECODE, HOLD (plus HALT, see REQ-025).
REQ-010 IDLE: one cycle after reset release, then FETCH; imem_req=0.
REQ-011 FETCH: imem_req=1 and imem_addr=fetch PC, held stable until the cycle imem_ack=1; request never withdrawn before ack.
REQ-012 On ack: capture imem_rdata into instruction register, latch fetch PC, go DECODE.
REQ-013 DECODE: one cycle; register all decode outputs; go HOLD; dec_valid=1 from the first HOLD cycle.
REQ-014 Latency: ack in cycle k -> dec_valid=1 in cycle k+2.
REQ-015 HOLD: outputs stable while dec_valid=1 and dec_ready=0; handshake completes in cycle m with dec_valid&dec_ready -> fetch PC += 4, FETCH with imem_req=1 in cycle m+1, dec_valid=0 in cycle m+1.
REQ-016 PC increment SHALL wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-017 Opcode[6:0] -> instType: 0000011->0 load, 0010011->1 imm, 0100011->2 store, 0110011->3 reg, 0110111->4 lui, 0010111->5 auipc, 1100011->6 brnch, 1100111->7 jalr, 1101111->8 jal.
REQ-018 Any other opcode or instr[1:0]!=2'b11: instType=4'hF, illegal=1; otherwise illegal=0.
REQ-019 fun3=instr[14:12], fun7=instr[30], rd=instr[11:7], rs1=instr[19:15], rs2=instr[24:20]; unused fields forced 0: rs2 for I-type (0,1,7), rd for S/B (2,6), rs1 and rs2 for U/J (4,5,8).
REQ-020 imm: I-type sign-extended instr[31:20]; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; U {instr[31:12],12'h0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}; all sign-extended to 32; reg and illegal -> 0.
REQ-021 pc output = address the decoded instruction was fetched from.
REQ-022 Redirect in IDLE/DECODE/HOLD: next fetch PC = {redirect_pc[31:2],2'b00}; DECODE/HOLD content discarded; dec_valid=0 next cycle; state FETCH next cycle.
REQ-023 Redirect in FETCH before or with ack: request completes normally, returned word discarded, then new FETCH at redirect address; a redirect in the ack cycle itself also discards.
REQ-024 Redirect coincident with HOLD handshake: redirect wins for the next address; instruction counts as consumed.

Reset
REQ-025 rst=0 asynchronously forces: state IDLE, fetch PC=RESET_PC, imem_req=0, dec_valid=0, illegal=0, all decode outputs 0; reset mid-fetch abandons the request and ignores any later ack until FETCH re-entered.

Configuration
REQ-026 Macro FETCH_DECODE_ILLEGAL_HALT_EN: defined -> illegal instruction at DECODE enters HALT: imem_req=0, dec_valid=0, illegal=1 held, redirects ignored, exit only by reset.
REQ-027 Not defined -> illegal instruction presented in HOLD with instType=4'hF, illegal=1, normal handshake and fetch continue; HALT state absent.

Verification
REQ-028 Reset release, imem acks each request in 1 cycle, dec_ready=1 -> imem_addr sequence 0x0,0x4,0x8; dec_valid 2 cycles after each ack.
REQ-029 imem_rdata=0xFFC10113 (addi x2,x2,-4) -> instType=1, rd=2, rs1=2, rs2=0, fun3=0, imm=0xFFFF_FFFC.
REQ-030 imem_rdata=0xFE0008E3 (beq x0,x0,-16) at pc 0x20, dec_ready=0 for 5 cycles -> outputs stable, instType=6, imm=0xFFFF_FFF0, pc=0x20.
REQ-031 redirect_valid=1, redirect_pc=0x103 while FETCH waits 3 cycles for ack -> returned word dropped, next imem_addr=0x100, no dec_valid for dropped word.
REQ-032 imem_rdata=0x00000000 -> with macro: HALT, imem_req=0 forever, illegal=1; without: dec_valid=1, instType=4'hF, next fetch pc+4.
REQ-033 RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000.

Source files
------------

// File: rtl/fetch_decode_if.sv
// Fetch/decode bus: instruction-memory handshake, redirect input and decoded control word.
// master = fetch_decode side, slave = memory/datapath side.
interface fetch_decode_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [3:0]  instType;
   logic [2:0]  fun3;
   logic        fun7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] pc;
   logic [31:0] imm;
   logic        illegal;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      input  redirect_valid, redirect_pc,
      output dec_valid,
      input  dec_ready,
      output instType, fun3, fun7, rd, rs1, rs2, pc, imm, illegal
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      output redirect_valid, redirect_pc,
      input  dec_valid,
      output dec_ready,
      input  instType, fun3, fun7, rd, rs1, rs2, pc, imm, illegal
   );
endinterface

// File: rtl/fetch_decode.sv
// RV32 single-instruction fetch + decode front end with redirect handling.
// Optional FETCH_DECODE_ILLEGAL_HALT_EN: an illegal instruction parks the unit in HALT until reset.
module fetch_decode #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst,
   fetch_decode_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_HOLD
`ifdef FETCH_DECODE_ILLEGAL_HALT_EN
      , S_HALT
`endif
   } state_t;

   state_t      r_state, w_nstate;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_ir;
   logic        r_redir_pend;
   logic [31:0] r_redir_pc;
   logic [3:0]  r_type;
   logic [2:0]  r_fun3;
   logic        r_fun7;
   logic [4:0]  r_rd, r_rs1, r_rs2;
   logic [31:0] r_pc, r_imm;
   logic        r_illegal;

   logic        w_imem_req, w_dec_valid;
   logic [31:0] w_redir_pc;
   logic [3:0]  w_type;
   logic        w_illegal;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [31:0] w_imm;

   assign w_redir_pc = bus.redirect_pc & ~32'h3;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_nstate;
   end

   always_comb begin
      w_nstate = r_state;
      case (r_state)
         S_IDLE:   w_nstate = S_FETCH;
         // a redirect seen during the request turns the returned word into a drop
         S_FETCH:  if (bus.imem_ack)
                      w_nstate = (r_redir_pend || bus.redirect_valid) ? S_FETCH : S_DECODE;
         S_DECODE: begin
            if (bus.redirect_valid) w_nstate = S_FETCH;
`ifdef FETCH_DECODE_ILLEGAL_HALT_EN
            else if (w_illegal)     w_nstate = S_HALT;
`endif
            else                    w_nstate = S_HOLD;
         end
         S_HOLD:   if (bus.redirect_valid || bus.dec_ready) w_nstate = S_FETCH;
`ifdef FETCH_DECODE_ILLEGAL_HALT_EN
         S_HALT:   w_nstate = S_HALT;
`endif
         default:  w_nstate = S_IDLE;
      endcase
   end

   always_comb begin
      w_imem_req  = (r_state == S_FETCH);
      w_dec_valid = (r_state == S_HOLD);
   end

   always_comb begin
      case (r_ir[6:0])
         7'b0000011: w_type = 4'd0;
         7'b0010011: w_type = 4'd1;
         7'b0100011: w_type = 4'd2;
         7'b0110011: w_type = 4'd3;
         7'b0110111: w_type = 4'd4;
         7'b0010111: w_type = 4'd5;
         7'b1100011: w_type = 4'd6;
         7'b1100111: w_type = 4'd7;
         7'b1101111: w_type = 4'd8;
         default:    w_type = 4'hF;
      endcase
      w_illegal = (w_type == 4'hF);
      w_rd  = r_ir[11:7];
      w_rs1 = r_ir[19:15];
      w_rs2 = r_ir[24:20];
      w_imm = '0;
      case (w_type)
         4'd0, 4'd1, 4'd7: begin
            w_rs2 = '0;
            w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
         end
         4'd2: begin
            w_rd  = '0;
            w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
         end
         4'd6: begin
            w_rd  = '0;
            w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
         end
         4'd4, 4'd5: begin
            w_rs1 = '0;
            w_rs2 = '0;
            w_imm = {r_ir[31:12], 12'h000};
         end
         4'd8: begin
            w_rs1 = '0;
            w_rs2 = '0;
            w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc   <= RESET_PC;
         r_ir         <= '0;
         r_redir_pend <= 1'b0;
         r_redir_pc   <= '0;
         r_type       <= '0;
         r_fun3       <= '0;
         r_fun7       <= 1'b0;
         r_rd         <= '0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_pc         <= '0;
         r_imm        <= '0;
         r_illegal    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.redirect_valid) r_fetch_pc <= w_redir_pc;
            S_FETCH: begin
               // imem_addr must stay put until ack, so a redirect is parked until then
               if (bus.imem_ack) begin
                  if (bus.redirect_valid) begin
                     r_fetch_pc   <= w_redir_pc;
                     r_redir_pend <= 1'b0;
                  end else if (r_redir_pend) begin
                     r_fetch_pc   <= r_redir_pc;
                     r_redir_pend <= 1'b0;
                  end else begin
                     r_ir <= bus.imem_rdata;
                  end
               end else if (bus.redirect_valid) begin
                  r_redir_pend <= 1'b1;
                  r_redir_pc   <= w_redir_pc;
               end
            end
            S_DECODE: begin
               r_type    <= w_type;
               r_fun3    <= r_ir[14:12];
               r_fun7    <= r_ir[30];
               r_rd      <= w_rd;
               r_rs1     <= w_rs1;
               r_rs2     <= w_rs2;
               r_imm     <= w_imm;
               r_illegal <= w_illegal;
               r_pc      <= r_fetch_pc;
               if (bus.redirect_valid) r_fetch_pc <= w_redir_pc;
            end
            S_HOLD: begin
               if (bus.redirect_valid)  r_fetch_pc <= w_redir_pc;
               else if (bus.dec_ready) r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_req  = w_imem_req;
   assign bus.imem_addr = r_fetch_pc;
   assign bus.dec_valid = w_dec_valid;
   assign bus.instType  = r_type;
   assign bus.fun3      = r_fun3;
   assign bus.fun7      = r_fun7;
   assign bus.rd        = r_rd;
   assign bus.rs1       = r_rs1;
   assign bus.rs2       = r_rs2;
   assign bus.pc        = r_pc;
   assign bus.imm       = r_imm;
   assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_fetch_decode.sv
// Randomized self-checking bench for fetch_decode against a spec-level decode/fetch model.
module tb_fetch_decode;

   typedef struct packed {
      logic [3:0]  t;
      logic        ill;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] pc;
      logic [31:0] imm;
   } dec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_pc;
   dec_t last_obs;
   logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6F};

   always #5 clk = ~clk;

   fetch_decode_if bus ();
   fetch_decode_if bus2 ();

   fetch_decode #(.RESET_PC(32'h0000_0000)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
   fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference decode: format chosen from the opcode table, immediates by shift arithmetic.
   function automatic dec_t ref_dec(input logic [31:0] w, input logic [31:0] a);
      dec_t d;
      byte  fmt;
      logic signed [31:0] s;
      d = '0;
      d.pc = a; d.f3 = w[14:12]; d.f7 = w[30];
      d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
      fmt = "X";
      for (int i = 0; i < 9; i++)
         if (w[6:0] == ops[i]) begin
            d.t = 4'(i);
            fmt = (i == 2) ? "S" : (i == 3) ? "R" : (i == 4 || i == 5) ? "U" :
                  (i == 6) ? "B" : (i == 8) ? "J" : "I";
         end
      case (fmt)
         "I": begin s = $signed({w[31:20], 20'h0}) >>> 20; d.imm = s; d.rs2 = 0; end
         "S": begin s = $signed({w[31:25], w[11:7], 20'h0}) >>> 20; d.imm = s; d.rd = 0; end
         "B": begin s = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0, 19'h0}) >>> 19; d.imm = s; d.rd = 0; end
         "U": begin d.imm = w & 32'hFFFF_F000; d.rs1 = 0; d.rs2 = 0; end
         "J": begin s = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0, 11'h0}) >>> 11; d.imm = s; d.rs1 = 0; d.rs2 = 0; end
         "R": d.imm = 0;
         default: begin d.t = 4'hF; d.ill = 1'b1; d.imm = 0; end
      endcase
      return d;
   endfunction

   function automatic dec_t obs();
      return dec_t'({bus.instType, bus.illegal, bus.fun3, bus.fun7, bus.rd, bus.rs1, bus.rs2, bus.pc, bus.imm});
   endfunction

   function automatic logic [31:0] rand_legal();
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 8)];
      return w;
   endfunction

   // One fetch/decode/handshake round trip; optional redirect presented at the handshake.
   task automatic run_instr(input logic [31:0] w, input int ack_dly, input int rdy_dly,
                            input bit redir, input logic [31:0] rpc, input bit redir_rdy);
      int   n;
      dec_t e;
      n = 0;
      while (bus.imem_req !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
         errors++; $display("FAIL fetch_addr req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, exp_pc);
      end
      for (int i = 0; i < ack_dly; i++) begin
         step();
         checks++;
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
            errors++; $display("FAIL req_held req=%b addr=%h expected addr=%h", bus.imem_req, bus.imem_addr, exp_pc);
         end
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = w;
      step();
      bus.imem_ack = 1'b0; bus.imem_rdata = $urandom;
      checks++;
      if (bus.dec_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL decode_cycle dec_valid=%b req=%b expected 0 0", bus.dec_valid, bus.imem_req);
      end
      step();
      e = ref_dec(w, exp_pc);
      last_obs = obs();
      checks++;
      if (bus.dec_valid !== 1'b1) begin
         errors++; $display("FAIL latency dec_valid=%b expected 1 two cycles after ack", bus.dec_valid);
      end
      checks++;
      if (last_obs !== e) begin
         errors++; $display("FAIL decode word=%h got %h expected %h", w, last_obs, e);
      end
      for (int i = 0; i < rdy_dly; i++) begin
         step();
         checks++;
         if (bus.dec_valid !== 1'b1 || obs() !== e) begin
            errors++; $display("FAIL hold_stable dec_valid=%b got %h expected %h", bus.dec_valid, obs(), e);
         end
      end
      bus.dec_ready = !redir || redir_rdy;
      bus.redirect_valid = redir; bus.redirect_pc = rpc;
      step();
      bus.dec_ready = 1'b0; bus.redirect_valid = 1'b0;
      exp_pc = redir ? (rpc & ~32'h3) : exp_pc + 32'd4;
      checks++;
      if (bus.dec_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
         errors++; $display("FAIL next_fetch dec_valid=%b req=%b addr=%h expected 0 1 %h", bus.dec_valid, bus.imem_req, bus.imem_addr, exp_pc);
      end
   endtask

   task automatic test_reset();
      bus.imem_ack = 0; bus.imem_rdata = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.dec_ready = 0;
      bus2.imem_ack = 0; bus2.imem_rdata = 0; bus2.redirect_valid = 0; bus2.redirect_pc = 0; bus2.dec_ready = 0;
      rst = 1'b0;
      repeat (3) step();
      checks++;
      if (bus.imem_req !== 1'b0 || bus.dec_valid !== 1'b0 || bus.illegal !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl req=%b dec_valid=%b illegal=%b expected 0 0 0", bus.imem_req, bus.dec_valid, bus.illegal);
      end
      checks++;
      if (obs() !== '0 || bus.imem_addr !== 32'h0) begin
         errors++; $display("FAIL reset_outputs got %h addr=%h expected all zero", obs(), bus.imem_addr);
      end
      checks++;
      if (bus2.imem_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL reset_pc_param addr=%h expected fffffffc", bus2.imem_addr);
      end
      rst = 1'b1;
      checks++;
      if (bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL idle_req req=%b expected 0", bus.imem_req);
      end
      step();
      exp_pc = 32'h0;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         errors++; $display("FAIL first_fetch req=%b addr=%h expected 1 0", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_wrap();
      checks++;
      if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_first req=%b addr=%h expected 1 fffffffc", bus2.imem_req, bus2.imem_addr);
      end
      bus2.imem_ack = 1'b1; bus2.imem_rdata = 32'h0000_0013;
      step();
      bus2.imem_ack = 1'b0;
      step();
      checks++;
      if (bus2.dec_valid !== 1'b1 || bus2.pc !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_decode dec_valid=%b pc=%h expected 1 fffffffc", bus2.dec_valid, bus2.pc);
      end
      bus2.dec_ready = 1'b1;
      step();
      bus2.dec_ready = 1'b0;
      checks++;
      if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_second req=%b addr=%h expected 1 00000000", bus2.imem_req, bus2.imem_addr);
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) run_instr(rand_legal(), 0, 0, 0, 0, 0);
   endtask

   task automatic test_addi();
      run_instr(32'hFFC1_0113, 0, 0, 0, 0, 0);
      checks++;
      if (last_obs.t !== 4'd1 || last_obs.rd !== 5'd2 || last_obs.rs1 !== 5'd2 || last_obs.rs2 !== 5'd0 ||
          last_obs.f3 !== 3'd0 || last_obs.imm !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL addi got %h expected type1 rd2 rs1 2 rs2 0 imm fffffffc", last_obs);
      end
   endtask

   task automatic test_branch_stall();
      run_instr(rand_legal(), 1, 0, 1, 32'h0000_0020, 0);
      run_instr(32'hFE00_08E3, 0, 5, 0, 0, 0);
      checks++;
      if (last_obs.t !== 4'd6 || last_obs.imm !== 32'hFFFF_FFF0 || last_obs.pc !== 32'h20) begin
         errors++; $display("FAIL beq got %h expected type6 imm fffffff0 pc 20", last_obs);
      end
   endtask

   // Redirect while a fetch is outstanding: the returned word must be dropped.
   task automatic test_redirect_fetch(input bit in_ack, input logic [31:0] rpc);
      if (!in_ack) begin
         bus.redirect_valid = 1'b1; bus.redirect_pc = rpc;
         step();
         bus.redirect_valid = 1'b0;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
               errors++; $display("FAIL redir_req_held req=%b addr=%h expected 1 %h", bus.imem_req, bus.imem_addr, exp_pc);
            end
            step();
         end
         bus.imem_ack = 1'b1; bus.imem_rdata = rand_legal();
      end else begin
         bus.imem_ack = 1'b1; bus.imem_rdata = rand_legal();
         bus.redirect_valid = 1'b1; bus.redirect_pc = rpc;
      end
      step();
      bus.imem_ack = 1'b0; bus.redirect_valid = 1'b0;
      exp_pc = rpc & ~32'h3;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.dec_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
            errors++; $display("FAIL redir_drop dec_valid=%b req=%b addr=%h expected 0 1 %h", bus.dec_valid, bus.imem_req, bus.imem_addr, exp_pc);
         end
         step();
      end
      run_instr(rand_legal(), 0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [31:0] w;
      for (int i = 0; i < 30; i++) begin
         w = rand_legal();
`ifndef FETCH_DECODE_ILLEGAL_HALT_EN
         if ($urandom_range(0, 7) == 0) w = $urandom;
`endif
         run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 4) == 0), $urandom, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_mid();
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0 || bus.dec_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset req=%b dec_valid=%b expected 0 0", bus.imem_req, bus.dec_valid);
      end
      step();
      rst = 1'b1;
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0013;
      step();
      bus.imem_ack = 1'b0;
      exp_pc = 32'h0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.dec_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
            errors++; $display("FAIL stale_ack dec_valid=%b req=%b addr=%h expected 0 1 0", bus.dec_valid, bus.imem_req, bus.imem_addr);
         end
         step();
      end
   endtask

   task automatic test_illegal();
`ifdef FETCH_DECODE_ILLEGAL_HALT_EN
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0;
      step();
      bus.imem_ack = 1'b0;
      step();
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.imem_req !== 1'b0 || bus.dec_valid !== 1'b0 || bus.illegal !== 1'b1) begin
            errors++; $display("FAIL halt req=%b dec_valid=%b illegal=%b expected 0 0 1", bus.imem_req, bus.dec_valid, bus.illegal);
         end
         step();
      end
      bus.redirect_valid = 1'b0;
`else
      logic [31:0] w;
      run_instr(32'h0, 0, 1, 0, 0, 0);
      checks++;
      if (last_obs.t !== 4'hF || last_obs.ill !== 1'b1 || last_obs.imm !== 32'h0) begin
         errors++; $display("FAIL illegal_zero got %h expected type f illegal 1 imm 0", last_obs);
      end
      w = rand_legal(); w[1:0] = 2'b01;
      run_instr(w, 1, 0, 0, 0, 0);
      checks++;
      if (last_obs.ill !== 1'b1) begin
         errors++; $display("FAIL illegal_low_bits illegal=%b expected 1", last_obs.ill);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_sequential();
      test_addi();
      test_branch_stall();
      test_redirect_fetch(0, 32'h0000_0103);
      test_redirect_fetch(1, 32'h0000_02EE);
      test_random();
      test_reset_mid();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

endmodule
